// File: rtl/mbisr_pkg.sv
// Shared types and default sizing for the MBISR repair controller.
package mbisr_pkg;

  localparam int unsigned DefAddrW     = 5;
  localparam int unsigned DefDataW     = 8;
  localparam int unsigned DefNumSpares = 4;

  typedef enum logic [1:0] {
    StIdle         = 2'd0,
    StCollect      = 2'd1,
    StRepaired     = 2'd2,
    StUnrepairable = 2'd3
  } mbisr_state_e;

endpackage

// File: rtl/mbisr_spare_cam.sv
// Spare word CAM: valid/address/data per entry, two address lookups
// (fail address and functional address), lowest-free-entry and full flags.
module mbisr_spare_cam
  import mbisr_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NUM_SPARES = DefNumSpares,
  localparam int unsigned IdxW      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              wr_i,
  input  logic [IdxW-1:0]   wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] fail_addr_i,
  output logic              fail_hit_o,
  input  logic [ADDR_W-1:0] f_addr_i,
  output logic              f_hit_o,
  output logic [IdxW-1:0]   f_idx_o,
  input  logic [IdxW-1:0]   rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [IdxW-1:0]   free_idx_o,
  output logic              full_o
);

  logic [NUM_SPARES-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]     addr_q [NUM_SPARES];
  logic [ADDR_W-1:0]     addr_d [NUM_SPARES];
  logic [DATA_W-1:0]     data_q [NUM_SPARES];
  logic [DATA_W-1:0]     data_d [NUM_SPARES];

  // Parallel compare of both lookup addresses against every valid entry.
  always_comb begin
    fail_hit_o = 1'b0;
    f_hit_o    = 1'b0;
    f_idx_o    = '0;
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (valid_q[i] && (addr_q[i] == fail_addr_i)) begin
        fail_hit_o = 1'b1;
      end
      if (valid_q[i] && (addr_q[i] == f_addr_i)) begin
        f_hit_o = 1'b1;
        f_idx_o = IdxW'(i);
      end
    end
  end

  // Lowest-numbered free entry; scanning downwards leaves the lowest one last.
  always_comb begin
    free_idx_o = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx_o = IdxW'(i);
      end
    end
  end

  assign full_o    = &valid_q;
  assign rd_data_o = data_q[rd_idx_i];

  // Next table contents: clear wins, otherwise allocate and/or spare write.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (clear_i) begin
      valid_d = '0;
      for (int i = 0; i < NUM_SPARES; i++) begin
        addr_d[i] = '0;
        data_d[i] = '0;
      end
    end else begin
      if (alloc_i) begin
        valid_d[free_idx_o] = 1'b1;
        addr_d[free_idx_o]  = alloc_addr_i;
        data_d[free_idx_o]  = '0;
      end
      if (wr_i) begin
        data_d[wr_idx_i] = wr_data_i;
      end
    end
  end

  // Table storage with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_SPARES; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mbisr_repair_ctrl.sv
// Built-in self-repair controller: collects MBIST fail addresses into spare
// words during a run, then redirects functional accesses to those spares.
module mbisr_repair_ctrl
  import mbisr_pkg::*;
#(
  parameter int unsigned ADDR_W     = DefAddrW,
  parameter int unsigned DATA_W     = DefDataW,
  parameter int unsigned NUM_SPARES = DefNumSpares,
  localparam int unsigned CntW      = $clog2(NUM_SPARES + 1),
  localparam int unsigned IdxW      = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              bist_start_i,
  input  logic              bist_fail_valid_i,
  input  logic [ADDR_W-1:0] bist_fail_addr_i,
  input  logic              bist_done_i,
  input  logic              f_en_i,
  input  logic              f_we_i,
  input  logic [ADDR_W-1:0] f_addr_i,
  input  logic [DATA_W-1:0] f_wdata_i,
  output logic [DATA_W-1:0] f_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              repair_done_o,
  output logic              unrepairable_o,
  output logic [CntW-1:0]   spares_used_o
);

  mbisr_state_e    state_q, state_d;
  logic            overflow_q, overflow_d;
  logic [CntW-1:0] used_q, used_d;
  logic            hit_q, hit_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            repair_done_q, repair_done_d;
  logic            unrep_q, unrep_d;

  logic              fail_hit, cam_full, f_hit;
  logic [IdxW-1:0]   f_idx;
  logic [DATA_W-1:0] spare_rdata;
  logic              fail_new, alloc, fail_ovf, remap, spare_wr;

  // bist_start in the same cycle discards any fail pulse.
  assign fail_new = (state_q == StCollect) && !bist_start_i && bist_fail_valid_i && !fail_hit;
  assign alloc    = fail_new && !cam_full;
  assign fail_ovf = fail_new && cam_full;
  assign remap    = (state_q == StRepaired) && f_en_i && f_hit;
  assign spare_wr = remap && f_we_i;

  mbisr_spare_cam #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .NUM_SPARES (NUM_SPARES)
  ) u_cam (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (bist_start_i),
    .alloc_i      (alloc),
    .alloc_addr_i (bist_fail_addr_i),
    .wr_i         (spare_wr),
    .wr_idx_i     (f_idx),
    .wr_data_i    (f_wdata_i),
    .fail_addr_i  (bist_fail_addr_i),
    .fail_hit_o   (fail_hit),
    .f_addr_i     (f_addr_i),
    .f_hit_o      (f_hit),
    .f_idx_o      (f_idx),
    .rd_idx_i     (idx_q),
    .rd_data_o    (spare_rdata),
    .free_idx_o   (),
    .full_o       (cam_full)
  );

  // State, overflow and allocation count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      overflow_q    <= 1'b0;
      used_q        <= '0;
      hit_q         <= 1'b0;
      idx_q         <= '0;
      repair_done_q <= 1'b0;
      unrep_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      overflow_q    <= overflow_d;
      used_q        <= used_d;
      hit_q         <= hit_d;
      idx_q         <= idx_d;
      repair_done_q <= repair_done_d;
      unrep_q       <= unrep_d;
    end
  end

  // Next-state: a start restarts collection from anywhere; the done decision
  // includes a fail arriving in the same cycle.
  always_comb begin
    state_d    = state_q;
    overflow_d = overflow_q;
    used_d     = used_q;
    if (bist_start_i) begin
      state_d    = StCollect;
      overflow_d = 1'b0;
      used_d     = '0;
    end else begin
      if (alloc) begin
        used_d = used_q + CntW'(1);
      end
      if (fail_ovf) begin
        overflow_d = 1'b1;
      end
      if ((state_q == StCollect) && bist_done_i) begin
        state_d = (overflow_q || fail_ovf) ? StUnrepairable : StRepaired;
      end
    end
  end

  // Outputs: status flags follow the next state; datapath steers remapped hits.
  always_comb begin
    repair_done_d = (state_d == StRepaired);
    unrep_d       = (state_d == StUnrepairable);
    mem_en_o      = f_en_i && !remap;
    mem_we_o      = f_en_i && f_we_i && !remap;
    mem_addr_o    = f_addr_i;
    mem_wdata_o   = f_wdata_i;
    hit_d         = remap && !f_we_i;
    idx_d         = hit_d ? f_idx : idx_q;
    f_rdata_o     = hit_q ? spare_rdata : mem_rdata_i;
  end

  assign repair_done_o  = repair_done_q;
  assign unrepairable_o = unrep_q;
  assign spares_used_o  = used_q;

endmodule

// File: tb/tb_mbisr_repair_ctrl.sv
// Self-checking bench for mbisr_repair_ctrl with a list-based repair model.
module tb_mbisr_repair_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NS = 4;
  localparam int MIdle = 0, MCol = 1, MRep = 2, MUnr = 3;

  logic          clk = 1'b0;
  logic          rst, bist_start, fail_valid, bist_done;
  logic [AW-1:0] fail_addr;
  logic          f_en, f_we;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata, f_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          repair_done, unrepairable;
  logic [2:0]    spares_used;

  mbisr_repair_ctrl dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .bist_start_i      (bist_start),
    .bist_fail_valid_i (fail_valid),
    .bist_fail_addr_i  (fail_addr),
    .bist_done_i       (bist_done),
    .f_en_i            (f_en),
    .f_we_i            (f_we),
    .f_addr_i          (f_addr),
    .f_wdata_i         (f_wdata),
    .f_rdata_o         (f_rdata),
    .mem_en_o          (mem_en),
    .mem_we_o          (mem_we),
    .mem_addr_o        (mem_addr),
    .mem_wdata_o       (mem_wdata),
    .mem_rdata_i       (mem_rdata),
    .repair_done_o     (repair_done),
    .unrepairable_o    (unrepairable),
    .spares_used_o     (spares_used)
  );

  always #5 clk = ~clk;

  // SRAM environment: 1-cycle synchronous read, preloadable from ref_mem.
  logic [DW-1:0] sram [32];
  logic [DW-1:0] ref_mem [32];
  logic          mem_load = 1'b0;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) sram[i] <= ref_mem[i];
    end else if (mem_en) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr];
    end
  end

  // Reference model: ordered list of repaired addresses and their spare data.
  int            mode;
  bit            ovf;
  logic [AW-1:0] tbl [$];
  logic [DW-1:0] spare [$];
  int            errors = 0;
  int            checks = 0;

  function automatic int find(input logic [AW-1:0] a);
    for (int i = 0; i < tbl.size(); i++) if (tbl[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [2:0] exp_used();
    return 3'(tbl.size());
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(input int m);
    mode = m;
    ovf  = 1'b0;
    tbl.delete();
    spare.delete();
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear(MIdle);
  endtask

  // One BIST-side cycle: drive pulses, advance the model, clock.
  task automatic bist_cycle(input bit st, input bit fv, input logic [AW-1:0] fa, input bit dn);
    bist_start = st;
    fail_valid = fv;
    fail_addr  = fa;
    bist_done  = dn;
    if (st) begin
      model_clear(MCol);
    end else if (mode == MCol) begin
      if (fv && find(fa) < 0) begin
        if (tbl.size() < NS) begin
          tbl.push_back(fa);
          spare.push_back('0);
        end else begin
          ovf = 1'b1;
        end
      end
      if (dn) mode = ovf ? MUnr : MRep;
    end
    tick();
    bist_start = 1'b0;
    fail_valid = 1'b0;
    bist_done  = 1'b0;
  endtask

  // Model side of one functional access; returns expected remap and read data.
  task automatic model_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output bit remap, output logic [DW-1:0] rd);
    int idx;
    idx   = (mode == MRep) ? find(a) : -1;
    remap = (idx >= 0);
    if (we) begin
      if (remap) spare[idx] = d;
      else       ref_mem[a] = d;
    end
    rd = remap ? spare[idx] : ref_mem[a];
  endtask

  // DUT side of one functional access; samples SRAM port then read data.
  task automatic drive_access(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                              output logic oen, output logic owe, output logic [AW-1:0] oaddr,
                              output logic [DW-1:0] ord);
    f_en    = 1'b1;
    f_we    = we;
    f_addr  = a;
    f_wdata = d;
    #1;
    oen   = mem_en;
    owe   = mem_we;
    oaddr = mem_addr;
    tick();
    ord  = f_rdata;
    f_en = 1'b0;
    f_we = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (repair_done !== 1'b0) begin
      errors++; $display("FAIL reset_repair_done: got %b expected 0", repair_done);
    end
    checks++;
    if (unrepairable !== 1'b0) begin
      errors++; $display("FAIL reset_unrepairable: got %b expected 0", unrepairable);
    end
    checks++;
    if (spares_used !== 3'd0) begin
      errors++; $display("FAIL reset_spares_used: got %0d expected 0", spares_used);
    end
  endtask

  task automatic test_clean_run();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm;
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 0, 0, 1);
    checks++;
    if (repair_done !== 1'b1 || unrepairable !== 1'b0 || spares_used !== 3'd0) begin
      errors++;
      $display("FAIL clean_flags: got rd=%b ur=%b used=%0d expected rd=1 ur=0 used=0",
               repair_done, unrepairable, spares_used);
    end
    model_access(1, 7, 8'h3C, rm, erd);
    drive_access(1, 7, 8'h3C, oen, owe, oa, ord);
    checks++;
    if (owe !== 1'b1 || oa !== 5'd7 || oen !== 1'b1) begin
      errors++; $display("FAIL clean_write: got en=%b we=%b addr=%0d expected 1 1 7", oen, owe, oa);
    end
  endtask

  task automatic test_single_fail();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm;
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 1, 7, 0);
    bist_cycle(0, 0, 0, 1);
    checks++;
    if (spares_used !== 3'd1 || repair_done !== 1'b1) begin
      errors++; $display("FAIL single_flags: got used=%0d rd=%b expected 1 1", spares_used, repair_done);
    end
    model_access(1, 7, 8'hA5, rm, erd);
    drive_access(1, 7, 8'hA5, oen, owe, oa, ord);
    checks++;
    if (oen !== 1'b0 || owe !== 1'b0) begin
      errors++; $display("FAIL single_remap_write: got en=%b we=%b expected 0 0", oen, owe);
    end
    model_access(0, 7, 0, rm, erd);
    drive_access(0, 7, 0, oen, owe, oa, ord);
    checks++;
    if (ord !== 8'hA5) begin
      errors++; $display("FAIL single_spare_read: got %h expected a5", ord);
    end
    model_access(0, 8, 0, rm, erd);
    drive_access(0, 8, 0, oen, owe, oa, ord);
    checks++;
    if (oen !== 1'b1 || oa !== 5'd8 || ord !== erd) begin
      errors++;
      $display("FAIL single_pass_addr8: got en=%b addr=%0d rd=%h expected 1 8 %h", oen, oa, ord, erd);
    end
  endtask

  task automatic test_duplicates();
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 1, 3, 0);
    bist_cycle(0, 1, 3, 0);
    bist_cycle(0, 1, 12, 0);
    bist_cycle(0, 1, 3, 0);
    bist_cycle(0, 0, 0, 1);
    checks++;
    if (spares_used !== 3'd2 || repair_done !== 1'b1) begin
      errors++; $display("FAIL dup_flags: got used=%0d rd=%b expected 2 1", spares_used, repair_done);
    end
  endtask

  task automatic test_overflow();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm;
    bist_cycle(1, 0, 0, 0);
    for (int a = 1; a <= 5; a++) bist_cycle(0, 1, 5'(a), 0);
    checks++;
    if (spares_used !== 3'd4 || repair_done !== 1'b0 || unrepairable !== 1'b0) begin
      errors++; $display("FAIL ovf_collect: got used=%0d rd=%b ur=%b expected 4 0 0",
                         spares_used, repair_done, unrepairable);
    end
    bist_cycle(0, 0, 0, 1);
    checks++;
    if (unrepairable !== 1'b1 || repair_done !== 1'b0) begin
      errors++; $display("FAIL ovf_done: got ur=%b rd=%b expected 1 0", unrepairable, repair_done);
    end
    model_access(1, 1, 8'h5A, rm, erd);
    drive_access(1, 1, 8'h5A, oen, owe, oa, ord);
    model_access(0, 1, 0, rm, erd);
    drive_access(0, 1, 0, oen, owe, oa, ord);
    checks++;
    if (oen !== 1'b1 || oa !== 5'd1 || ord !== 8'h5A) begin
      errors++; $display("FAIL ovf_pass: got en=%b addr=%0d rd=%h expected 1 1 5a", oen, oa, ord);
    end
  endtask

  task automatic test_fail_with_done();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm;
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 1, 9, 1);
    checks++;
    if (spares_used !== 3'd1 || repair_done !== 1'b1) begin
      errors++; $display("FAIL fwd_flags: got used=%0d rd=%b expected 1 1", spares_used, repair_done);
    end
    model_access(1, 9, 8'hC3, rm, erd);
    drive_access(1, 9, 8'hC3, oen, owe, oa, ord);
    checks++;
    if (oen !== 1'b0) begin
      errors++; $display("FAIL fwd_remap: got en=%b expected 0", oen);
    end
    // Fifth unique fail coincident with done must still mark the run unrepairable.
    bist_cycle(1, 0, 0, 0);
    for (int a = 20; a < 24; a++) bist_cycle(0, 1, 5'(a), 0);
    bist_cycle(0, 1, 30, 1);
    checks++;
    if (unrepairable !== 1'b1 || repair_done !== 1'b0 || spares_used !== 3'd4) begin
      errors++; $display("FAIL fwd_ovf: got ur=%b rd=%b used=%0d expected 1 0 4",
                         unrepairable, repair_done, spares_used);
    end
  endtask

  task automatic test_reset_mid_collect();
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 1, 4, 0);
    reset_dut();
    checks++;
    if (spares_used !== 3'd0 || repair_done !== 1'b0 || unrepairable !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags: got used=%0d rd=%b ur=%b expected 0 0 0",
                         spares_used, repair_done, unrepairable);
    end
    bist_cycle(0, 0, 0, 1);
    checks++;
    if (repair_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_done_ignored: got rd=%b expected 0", repair_done);
    end
  endtask

  task automatic test_rerun();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm;
    bist_cycle(1, 0, 0, 0);
    bist_cycle(0, 1, 7, 0);
    bist_cycle(0, 0, 0, 1);
    bist_cycle(1, 1, 5, 0);
    checks++;
    if (repair_done !== 1'b0 || spares_used !== 3'd0) begin
      errors++; $display("FAIL rerun_clear: got rd=%b used=%0d expected 0 0", repair_done, spares_used);
    end
    model_access(0, 7, 0, rm, erd);
    drive_access(0, 7, 0, oen, owe, oa, ord);
    checks++;
    if (oen !== 1'b1 || oa !== 5'd7 || ord !== erd) begin
      errors++; $display("FAIL rerun_pass: got en=%b addr=%0d rd=%h expected 1 7 %h", oen, oa, ord, erd);
    end
  endtask

  task automatic test_random();
    logic oen, owe; logic [AW-1:0] oa; logic [DW-1:0] ord, erd; bit rm, we;
    logic [AW-1:0] a; logic [DW-1:0] d;
    for (int run = 0; run < 20; run++) begin
      bist_cycle(1, $urandom_range(0, 1), 5'($urandom_range(0, 7)), 0);
      for (int k = 0; k < int'($urandom_range(0, 6)); k++) begin
        bist_cycle(0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 0);
      end
      bist_cycle(0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)), 1);
      // Fail pulse after the run is finished must be ignored.
      bist_cycle(0, 1, 5'($urandom_range(0, 7)), 0);
      checks++;
      if (spares_used !== exp_used() || repair_done !== (mode == MRep) ||
          unrepairable !== (mode == MUnr)) begin
        errors++;
        $display("FAIL rand_flags run %0d: got used=%0d rd=%b ur=%b expected %0d %b %b", run,
                 spares_used, repair_done, unrepairable, exp_used(), mode == MRep, mode == MUnr);
      end
      for (int k = 0; k < 12; k++) begin
        we = $urandom_range(0, 1);
        a  = 5'($urandom_range(0, 9));
        d  = 8'($urandom);
        model_access(we, a, d, rm, erd);
        drive_access(we, a, d, oen, owe, oa, ord);
        checks++;
        if (oen !== !rm || owe !== (we && !rm) || (!rm && oa !== a)) begin
          errors++;
          $display("FAIL rand_port run %0d: got en=%b we=%b addr=%0d expected %b %b %0d", run,
                   oen, owe, oa, !rm, we && !rm, a);
        end
        if (!we) begin
          checks++;
          if (ord !== erd) begin
            errors++; $display("FAIL rand_read run %0d addr %0d: got %h expected %h", run, a, ord, erd);
          end
        end
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    bist_start = 1'b0;
    fail_valid = 1'b0;
    fail_addr  = '0;
    bist_done  = 1'b0;
    f_en       = 1'b0;
    f_we       = 1'b0;
    f_addr     = '0;
    f_wdata    = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'($urandom);
    mem_load = 1'b1;
    tick();
    mem_load = 1'b0;
    test_reset();
    test_clean_run();
    test_single_fail();
    test_duplicates();
    test_overflow();
    test_fail_with_done();
    test_reset_mid_collect();
    test_rerun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
